// File: rtl/instruction_prefetch_queue_if.sv
// Fetch-side memory port, branch redirect and decode handshake of the prefetch queue.
interface instruction_prefetch_queue_if #(
   parameter int unsigned ADDR_WIDTH = 32
);
   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_ack;
   logic [31:0]           mem_rdata;
   logic                  redirect;
   logic [ADDR_WIDTH-1:0] redirect_target;
   logic                  dec_valid;
   logic                  dec_ready;
   logic [31:0]           dec_instr;
   logic [ADDR_WIDTH-1:0] dec_pc;
   logic                  dec_is_compact;

   modport master (
      output mem_req, mem_addr, dec_valid, dec_instr, dec_pc, dec_is_compact,
      input  mem_ack, mem_rdata, redirect, redirect_target, dec_ready
   );

   modport slave (
      input  mem_req, mem_addr, dec_valid, dec_instr, dec_pc, dec_is_compact,
      output mem_ack, mem_rdata, redirect, redirect_target, dec_ready
   );
endinterface

// File: rtl/instruction_prefetch_queue.sv
// Parcel-based instruction prefetch queue: buffers 16-bit parcels from 32-bit fetches and
// presents whole 16/32-bit instructions (including word-straddling ones) to decode.
module instruction_prefetch_queue #(
   parameter int unsigned           DEPTH      = 4,
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   instruction_prefetch_queue_if.master bus
);
   localparam int unsigned NPARCEL = 2 * DEPTH;
   localparam int unsigned PW      = $clog2(NPARCEL);
   localparam int unsigned CW      = $clog2(NPARCEL + 1);
   localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] HALF_MASK = ~ADDR_WIDTH'(1);

   logic [15:0]           ram_q [NPARCEL];
   logic [15:0]           ram_d [NPARCEL];
   logic [PW-1:0]         head_q, head_d, tail_q, tail_d;
   logic [CW-1:0]         count_q, count_d;
   logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
   logic [ADDR_WIDTH-1:0] head_pc_q, head_pc_d;
   logic                  drop_low_q, drop_low_d;
   logic                  run_q;

   logic [15:0] p0_c, p1_c;
   logic        compact_c, valid_c, room_c, mem_req_c, fill_c, consume_c;
   logic [1:0]  n_in_c, n_out_c;

   // Instruction view of the head parcel(s); pointer arithmetic wraps at the buffer size.
   assign p0_c      = ram_q[head_q];
   assign p1_c      = ram_q[head_q + PW'(1)];
   assign compact_c = (p0_c[1:0] != 2'b11);
   assign valid_c   = compact_c ? (count_q >= CW'(1)) : (count_q >= CW'(2));
   assign room_c    = (CW'(NPARCEL) - count_q) >= CW'(2);

   // run_q holds the request low until the first edge after reset release.
   assign mem_req_c = run_q && room_c && !bus.redirect;
   assign fill_c    = mem_req_c && bus.mem_ack;
   assign consume_c = valid_c && bus.dec_ready && !bus.redirect;

   assign bus.mem_req        = mem_req_c;
   assign bus.mem_addr       = fetch_addr_q;
   assign bus.dec_valid      = valid_c;
   assign bus.dec_instr      = !valid_c ? 32'h0 : (compact_c ? {16'h0, p0_c} : {p1_c, p0_c});
   assign bus.dec_pc         = valid_c ? head_pc_q : '0;
   assign bus.dec_is_compact = valid_c && compact_c;

   always_comb begin
      ram_d        = ram_q;
      head_d       = head_q;
      tail_d       = tail_q;
      count_d      = count_q;
      fetch_addr_d = fetch_addr_q;
      head_pc_d    = head_pc_q;
      drop_low_d   = drop_low_q;
      n_in_c       = 2'd0;
      n_out_c      = 2'd0;

      if (fill_c) begin
         if (drop_low_q) begin
            ram_d[tail_q] = bus.mem_rdata[31:16];
            n_in_c        = 2'd1;
            drop_low_d    = 1'b0;
         end else begin
            ram_d[tail_q]          = bus.mem_rdata[15:0];
            ram_d[tail_q + PW'(1)] = bus.mem_rdata[31:16];
            n_in_c                 = 2'd2;
         end
         fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(4);
      end

      if (consume_c) begin
         n_out_c   = compact_c ? 2'd1 : 2'd2;
         head_pc_d = head_pc_q + (compact_c ? ADDR_WIDTH'(2) : ADDR_WIDTH'(4));
      end

      head_d  = head_q + PW'(n_out_c);
      tail_d  = tail_q + PW'(n_in_c);
      count_d = count_q + CW'(n_in_c) - CW'(n_out_c);

      // Redirect overrides any same-cycle fill or consume.
      if (bus.redirect) begin
         head_d       = '0;
         tail_d       = '0;
         count_d      = '0;
         fetch_addr_d = bus.redirect_target & WORD_MASK;
         head_pc_d    = bus.redirect_target & HALF_MASK;
         drop_low_d   = bus.redirect_target[1];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(NPARCEL); i++) ram_q[i] <= '0;
         head_q       <= '0;
         tail_q       <= '0;
         count_q      <= '0;
         fetch_addr_q <= RESET_PC & WORD_MASK;
         head_pc_q    <= RESET_PC & HALF_MASK;
         drop_low_q   <= RESET_PC[1];
         run_q        <= 1'b0;
      end else begin
         ram_q        <= ram_d;
         head_q       <= head_d;
         tail_q       <= tail_d;
         count_q      <= count_d;
         fetch_addr_q <= fetch_addr_d;
         head_pc_q    <= head_pc_d;
         drop_low_q   <= drop_low_d;
         run_q        <= 1'b1;
      end
   end
endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Randomized bench for instruction_prefetch_queue against an address-level model of the
// fetch stream: occupancy is derived from fetch address minus decode PC.
module tb_instruction_prefetch_queue;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned AW      = 32;
   localparam int          NPARCEL = 2 * DEPTH;

   logic clk = 1'b0;
   logic rst_n;

   instruction_prefetch_queue_if #(.ADDR_WIDTH(AW)) bus ();

   instruction_prefetch_queue #(
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW),
      .RESET_PC   ('0)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   logic [31:0]   mem [256];
   logic [AW-1:0] m_pc, m_fetch;
   bit            m_run;
   int            n_tests = 0;
   int            n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [15:0] hw(input logic [AW-1:0] a);
      logic [31:0] w;
      w = mem[a[9:2]];
      return a[1] ? w[31:16] : w[15:0];
   endfunction

   // Parcels held = bytes fetched beyond the decode PC, halved; negative while a dropped
   // low parcel is still pending.
   function automatic int m_count();
      int d;
      d = int'($signed(m_fetch - m_pc));
      return (d < 0) ? 0 : d / 2;
   endfunction

   task automatic cycle(input bit ack, input bit rdy, input bit redir, input logic [AW-1:0] tgt);
      logic [15:0] p;
      bit          c, ev, er;
      int          cnt;
      logic [31:0] ei;
      @(negedge clk);
      bus.mem_ack         = ack;
      bus.dec_ready       = rdy;
      bus.redirect        = redir;
      bus.redirect_target = tgt;
      bus.mem_rdata       = mem[bus.mem_addr[9:2]];
      #1;
      p   = hw(m_pc);
      c   = (p[1:0] != 2'b11);
      cnt = m_count();
      ev  = c ? (cnt >= 1) : (cnt >= 2);
      ei  = !ev ? 32'h0 : (c ? {16'h0, p} : {hw(m_pc + 2), p});
      er  = m_run && ((NPARCEL - cnt) >= 2) && !redir;
      chk("mem_req",        64'(bus.mem_req),        64'(er));
      chk("mem_addr",       64'(bus.mem_addr),       64'(m_fetch));
      chk("dec_valid",      64'(bus.dec_valid),      64'(ev));
      chk("dec_instr",      64'(bus.dec_instr),      64'(ei));
      chk("dec_pc",         64'(bus.dec_pc),         ev ? 64'(m_pc) : 64'h0);
      chk("dec_is_compact", 64'(bus.dec_is_compact), 64'(ev && c));
      @(posedge clk);
      if (redir) begin
         m_pc    = tgt & ~AW'(1);
         m_fetch = tgt & ~AW'(3);
      end else begin
         if (er && ack) m_fetch = m_fetch + AW'(4);
         if (ev && rdy) m_pc = m_pc + (c ? AW'(2) : AW'(4));
      end
      m_run = 1'b1;
   endtask

   task automatic do_reset();
      rst_n               = 1'b0;
      bus.mem_ack         = 1'b0;
      bus.dec_ready       = 1'b0;
      bus.redirect        = 1'b0;
      bus.redirect_target = '0;
      bus.mem_rdata       = '0;
      #1;
      chk("rst_mem_req",   64'(bus.mem_req),   64'h0);
      chk("rst_dec_valid", 64'(bus.dec_valid), 64'h0);
      chk("rst_dec_instr", 64'(bus.dec_instr), 64'h0);
      chk("rst_dec_pc",    64'(bus.dec_pc),    64'h0);
      chk("rst_mem_addr",  64'(bus.mem_addr),  64'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n       = 1'b1;
      bus.mem_ack = 1'b1;
      #1;
      chk("req_before_first_edge", 64'(bus.mem_req), 64'h0);
      m_pc    = '0;
      m_fetch = '0;
      m_run   = 1'b0;
      @(posedge clk);
      m_run = 1'b1;
   endtask

   task automatic fill_mem_random();
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
   endtask

   initial begin
      // Two plain 32-bit instructions
      fill_mem_random();
      mem[0] = 32'h0050_0093;
      mem[1] = 32'h0010_0113;
      do_reset();
      repeat (6) cycle(1'b1, 1'b1, 1'b0, '0);

      // Two compact parcels in one word
      fill_mem_random();
      mem[0] = 32'h0001_4501;
      do_reset();
      repeat (5) cycle(1'b1, 1'b1, 1'b0, '0);

      // Compact followed by a word-straddling 32-bit instruction, acks spaced out
      fill_mem_random();
      mem[0] = 32'h0093_4501;
      mem[1] = 32'h0000_0050;
      do_reset();
      cycle(1'b1, 1'b1, 1'b0, '0);
      repeat (3) cycle(1'b0, 1'b1, 1'b0, '0);
      repeat (5) cycle(1'b1, 1'b1, 1'b0, '0);

      // Stall decode until full, then drain
      fill_mem_random();
      do_reset();
      repeat (8) cycle(1'b1, 1'b0, 1'b0, '0);
      repeat (8) cycle(1'b1, 1'b1, 1'b0, '0);

      // Redirect to a misaligned target while full with ack asserted
      repeat (6) cycle(1'b1, 1'b0, 1'b0, '0);
      cycle(1'b1, 1'b1, 1'b1, AW'(32'h102));
      repeat (8) cycle(1'b1, 1'b1, 1'b0, '0);

      // Random traffic with occasional redirects and one asynchronous reset
      fill_mem_random();
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) begin
            repeat (6) cycle(1'b1, 1'b0, 1'b0, '0);
            @(negedge clk);
            bus.dec_ready = 1'b0;
            #2;
            chk("pre_async_valid", 64'(bus.dec_valid), 64'h1);
            rst_n = 1'b0;
            #1;
            chk("async_dec_valid", 64'(bus.dec_valid), 64'h0);
            chk("async_dec_instr", 64'(bus.dec_instr), 64'h0);
            chk("async_mem_req",   64'(bus.mem_req),   64'h0);
            do_reset();
         end
         cycle(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 40) == 0,
               AW'($urandom_range(0, 1023)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
